hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage RV32IM core.
- Generates every stall and flush for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Covers four cases: load-use bubbles (the case operand forwarding cannot cover), taken-branch squashes, multi-cycle mul/div occupancy of EX, and data-memory wait states.
- Sits beside the forwarding unit and drives the pipeline-register enable/clear controls.

Parameters:
RegAddrWidth, 5, register address width
MulDivTimeout, 40, max cycles in MULDIV_WAIT before forced release
CntWidth, 32, width of performance counters (optional feature only)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous active-high reset
ID_RS1  input  RegAddrWidth  rs1 of instruction in ID
ID_RS2  input  RegAddrWidth  rs2 of instruction in ID
ID_RS1_used  input  1  ID instruction reads rs1
ID_RS2_used  input  1  ID instruction reads rs2
EX_rd  input  RegAddrWidth  destination of instruction in EX
EX_Reg_File_EN  input  1  EX instruction writes register file
EX_Mem_Read_EN  input  1  EX instruction is a load
EX_MulDiv_EN  input  1  EX instruction is mul/div
EX_Branch_Taken  input  1  branch/jump in EX resolved taken
MEM_Mem_Access  input  1  MEM instruction accesses data memory
dmem_ready  input  1  data memory completes access this cycle
muldiv_done  input  1  mul/div result valid this cycle
stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  output  1 each  hold register
flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  output  1 each  load bubble
muldiv_start  output  1  one-cycle start pulse to mul/div unit
muldiv_timeout  output  1  one-cycle pulse on forced release
stall_cycles, flush_cycles  output  CntWidth each  performance counters

Behaviour:
- FSM states: RUN, MULDIV_WAIT. State is RUN on reset.
- While reset is high, all outputs are 0 (combinational outputs gated) and the timeout counter clears. Reset mid-WAIT returns to RUN with no muldiv_timeout pulse.
- Load-use condition: EX_Mem_Read_EN & EX_Reg_File_EN & EX_rd!=0 & ((ID_RS1_used & ID_RS1==EX_rd) | (ID_RS2_used & ID_RS2==EX_rd)).

RUN priority, highest first; all outputs are combinational:
1. MEM_Mem_Access & !dmem_ready: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_mem_wb=1. The branch flush and the mul/div start are deferred until dmem_ready. State stays RUN.
2. EX_Branch_Taken: flush_if_id=1, flush_id_ex=1. Any load-use in ID is ignored because that instruction is squashed.
3. EX_MulDiv_EN:
   - muldiv_start=1 and stall_pc, stall_if_id, stall_id_ex=1, flush_ex_mem=1.
   - Next state MULDIV_WAIT.
4. Load-use: stall_pc, stall_if_id=1, flush_id_ex=1 for exactly one cycle. The bubble in EX removes the condition naturally; no state is needed.
5. Otherwise all outputs are 0.

MULDIV_WAIT:
- muldiv_done=0: stall_pc, stall_if_id, stall_id_ex=1, flush_ex_mem=1. The timeout counter increments each cycle.
- muldiv_done=1: all stalls are 0 this cycle so the result advances to MEM. Next state RUN, counter cleared. muldiv_start is never reasserted for the same instruction.
- Counter reaching MulDivTimeout-1 without done: muldiv_timeout=1 for one cycle, same release as done, next state RUN.
- muldiv_done is ignored in RUN. Branch and dmem inputs are ignored in WAIT: MEM holds only bubbles, and the EX instruction is the mul/div.
- Timeout counter width is $clog2(MulDivTimeout+1) and never wraps.

Optional Feature:
- Macro: HAZARD_PERF_COUNTERS_EN.
- Defined: stall_cycles increments on every cycle with stall_pc=1. flush_cycles increments on every cycle with flush_if_id|flush_id_ex=1. Both are CntWidth-bit, wrap modulo 2^CntWidth, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Decomposition:
- Shared pipeline package holds:
  - hazard_state_e enum {RUN, MULDIV_WAIT}
  - RegAddrWidth constant
  - a stage_ctrl_t struct bundling the stall/flush bits per stage, for use by the core top-level.
- No sub-module; the optional counters are inline generate logic.

Test Plan:
- Load-use: EX lw x5 (Mem_Read, rd=5), ID add reads rs1=5 -> one cycle stall_pc=stall_if_id=flush_id_ex=1, next cycle all 0. Repeat with rd=0 -> no stall.
- Branch and load-use together: EX_Branch_Taken=1 with a load-use match -> flush_if_id=flush_id_ex=1, stall_pc=0.
- Mul/div completion: EX_MulDiv_EN, muldiv_done after 33 cycles:
  - muldiv_start high only in the first cycle.
  - Stalls held 33 cycles and drop in the done cycle.
  - State returns to RUN.
- Data-memory wait: MEM_Mem_Access with dmem_ready low 3 cycles and EX_Branch_Taken=1:
  - All four stalls plus flush_mem_wb held 3 cycles.
  - The branch flush appears only in the ready cycle.
- Timeout and reset:
  - No muldiv_done -> muldiv_timeout pulse at cycle 40, release to RUN.
  - Separate run: reset asserted at cycle 10 of WAIT -> outputs 0 next cycle, RUN, no timeout pulse.
- Counters, with HAZARD_PERF_COUNTERS_EN defined, running the load-use, branch and mul/div scenarios above (33-cycle mul/div) -> stall_cycles=35 (1 load-use + 34 mul/div stalled cycles), flush_cycles=2 (1 load-use bubble + 1 branch squash).

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// hazard_stall_controller_pkg: shared pipeline hazard state, stage control bundle and register width
package hazard_stall_controller_pkg;

    localparam int RegAddrWidth = 5;

    typedef enum logic {
        RUN,
        MULDIV_WAIT
    } hazard_state_e;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
        logic flush_mem_wb;
    } stage_ctrl_t;

endpackage

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: 5-stage pipeline stall/flush sequencer; HAZARD_PERF_COUNTERS_EN adds stall/flush cycle counters
module hazard_stall_controller #(
    parameter int RegAddrWidth  = hazard_stall_controller_pkg::RegAddrWidth,
    parameter int MulDivTimeout = 40,
    parameter int CntWidth      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [RegAddrWidth-1:0] ID_RS1,
    input  logic [RegAddrWidth-1:0] ID_RS2,
    input  logic                    ID_RS1_used,
    input  logic                    ID_RS2_used,
    input  logic [RegAddrWidth-1:0] EX_rd,
    input  logic                    EX_Reg_File_EN,
    input  logic                    EX_Mem_Read_EN,
    input  logic                    EX_MulDiv_EN,
    input  logic                    EX_Branch_Taken,
    input  logic                    MEM_Mem_Access,
    input  logic                    dmem_ready,
    input  logic                    muldiv_done,
    output logic                    stall_pc,
    output logic                    stall_if_id,
    output logic                    stall_id_ex,
    output logic                    stall_ex_mem,
    output logic                    flush_if_id,
    output logic                    flush_id_ex,
    output logic                    flush_ex_mem,
    output logic                    flush_mem_wb,
    output logic                    muldiv_start,
    output logic                    muldiv_timeout,
    output logic [CntWidth-1:0]     stall_cycles,
    output logic [CntWidth-1:0]     flush_cycles
);
    import hazard_stall_controller_pkg::*;

    localparam int TW = $clog2(MulDivTimeout + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MulDivTimeout - 1);

    hazard_state_e state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    stage_ctrl_t ctrl;
    logic start, tmo, load_use, mem_wait;

    assign mem_wait = MEM_Mem_Access && !dmem_ready;
    assign load_use = EX_Mem_Read_EN && EX_Reg_File_EN && EX_rd != '0 &&
                      ((ID_RS1_used && ID_RS1 == EX_rd) || (ID_RS2_used && ID_RS2 == EX_rd));

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        tmo_d   = '0;
        start   = 1'b0;
        tmo     = 1'b0;
        if (reset) begin
            state_d = RUN;
        end else if (state_q == MULDIV_WAIT) begin
            if (muldiv_done || tmo_q == TMO_LAST) begin
                state_d = RUN;
                tmo     = !muldiv_done;
            end else begin
                ctrl.stall_pc     = 1'b1;
                ctrl.stall_if_id  = 1'b1;
                ctrl.stall_id_ex  = 1'b1;
                ctrl.flush_ex_mem = 1'b1;
                tmo_d             = tmo_q + TW'(1);
            end
        end else if (mem_wait) begin
            // branch squash and mul/div launch wait until memory frees the pipe
            ctrl.stall_pc     = 1'b1;
            ctrl.stall_if_id  = 1'b1;
            ctrl.stall_id_ex  = 1'b1;
            ctrl.stall_ex_mem = 1'b1;
            ctrl.flush_mem_wb = 1'b1;
        end else if (EX_Branch_Taken) begin
            ctrl.flush_if_id = 1'b1;
            ctrl.flush_id_ex = 1'b1;
        end else if (EX_MulDiv_EN) begin
            start             = 1'b1;
            ctrl.stall_pc     = 1'b1;
            ctrl.stall_if_id  = 1'b1;
            ctrl.stall_id_ex  = 1'b1;
            ctrl.flush_ex_mem = 1'b1;
            state_d           = MULDIV_WAIT;
        end else if (load_use) begin
            ctrl.stall_pc    = 1'b1;
            ctrl.stall_if_id = 1'b1;
            ctrl.flush_id_ex = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    assign stall_pc       = ctrl.stall_pc;
    assign stall_if_id    = ctrl.stall_if_id;
    assign stall_id_ex    = ctrl.stall_id_ex;
    assign stall_ex_mem   = ctrl.stall_ex_mem;
    assign flush_if_id    = ctrl.flush_if_id;
    assign flush_id_ex    = ctrl.flush_id_ex;
    assign flush_ex_mem   = ctrl.flush_ex_mem;
    assign flush_mem_wb   = ctrl.flush_mem_wb;
    assign muldiv_start   = start;
    assign muldiv_timeout = tmo;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    assign stall_cnt_d = stall_cnt_q + CntWidth'(ctrl.stall_pc);
    assign flush_cnt_d = flush_cnt_q + CntWidth'(ctrl.flush_if_id | ctrl.flush_id_ex);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed scenarios plus randomized traffic against a rule-level reference model
module tb_hazard_stall_controller;

    localparam int T = 40;
    // expected vector order: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
    // flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, muldiv_start, muldiv_timeout
    localparam logic [9:0] V_IDLE = 10'b0000000000;
    localparam logic [9:0] V_LU   = 10'b1100010000;
    localparam logic [9:0] V_BR   = 10'b0000110000;
    localparam logic [9:0] V_MDS  = 10'b1110001010;
    localparam logic [9:0] V_MDW  = 10'b1110001000;
    localparam logic [9:0] V_MEM  = 10'b1111000100;
    localparam logic [9:0] V_TMO  = 10'b0000000001;

    logic clk = 1'b0, reset = 1'b0;
    logic [4:0] ID_RS1 = '0, ID_RS2 = '0, EX_rd = '0;
    logic ID_RS1_used = 0, ID_RS2_used = 0, EX_Reg_File_EN = 0, EX_Mem_Read_EN = 0;
    logic EX_MulDiv_EN = 0, EX_Branch_Taken = 0, MEM_Mem_Access = 0, dmem_ready = 0, muldiv_done = 0;
    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, muldiv_start, muldiv_timeout;
    logic [31:0] stall_cycles, flush_cycles;
    logic [9:0] outv;

    int n_vec = 0, n_err = 0;
    bit m_wait = 0;
    int m_cnt = 0, m_sc = 0, m_fc = 0;

    hazard_stall_controller dut (
        .clk(clk), .reset(reset),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RS1_used(ID_RS1_used), .ID_RS2_used(ID_RS2_used),
        .EX_rd(EX_rd), .EX_Reg_File_EN(EX_Reg_File_EN), .EX_Mem_Read_EN(EX_Mem_Read_EN),
        .EX_MulDiv_EN(EX_MulDiv_EN), .EX_Branch_Taken(EX_Branch_Taken),
        .MEM_Mem_Access(MEM_Mem_Access), .dmem_ready(dmem_ready), .muldiv_done(muldiv_done),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
        .muldiv_start(muldiv_start), .muldiv_timeout(muldiv_timeout),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    assign outv = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex,
                   flush_ex_mem, flush_mem_wb, muldiv_start, muldiv_timeout};

    always #5 clk = ~clk;

    function automatic logic [9:0] exp_vec();
        bit lu;
        lu = EX_Mem_Read_EN && EX_Reg_File_EN && EX_rd != 0 &&
             ((ID_RS1_used && ID_RS1 == EX_rd) || (ID_RS2_used && ID_RS2 == EX_rd));
        if (reset) return V_IDLE;
        if (m_wait) return muldiv_done ? V_IDLE : (m_cnt == T - 1) ? V_TMO : V_MDW;
        if (MEM_Mem_Access && !dmem_ready) return V_MEM;
        if (EX_Branch_Taken) return V_BR;
        if (EX_MulDiv_EN) return V_MDS;
        return lu ? V_LU : V_IDLE;
    endfunction

    task automatic tick();
        logic [9:0] e;
        e = exp_vec();
        @(posedge clk);
        if (reset) begin
            m_wait = 0; m_cnt = 0; m_sc = 0; m_fc = 0;
        end else begin
            m_sc += int'(e[9]);
            m_fc += int'(e[5] | e[4]);
            if (m_wait) begin
                if (muldiv_done || m_cnt == T - 1) begin m_wait = 0; m_cnt = 0; end
                else m_cnt++;
            end else if (e[1]) m_wait = 1;
        end
        #1;
    endtask

    task automatic idle();
        {ID_RS1, ID_RS2, EX_rd} = '0;
        {ID_RS1_used, ID_RS2_used, EX_Reg_File_EN, EX_Mem_Read_EN} = '0;
        {EX_MulDiv_EN, EX_Branch_Taken, MEM_Mem_Access, dmem_ready, muldiv_done} = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        EX_MulDiv_EN = 1; EX_Branch_Taken = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (outv !== V_IDLE) begin n_err++; $display("FAIL reset_out: got %b want %b", outv, V_IDLE); end
            tick();
        end
        @(negedge clk);
        n_vec++;
        if (stall_cycles !== 0 || flush_cycles !== 0) begin
            n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cycles, flush_cycles);
        end
        reset = 0; idle();
        tick();
    endtask

    task automatic test_load_use();
        EX_Mem_Read_EN = 1; EX_Reg_File_EN = 1; EX_rd = 5; ID_RS1 = 5; ID_RS1_used = 1; ID_RS2 = 7; ID_RS2_used = 1;
        @(negedge clk);
        n_vec++;
        if (outv !== V_LU) begin n_err++; $display("FAIL load_use: got %b want %b", outv, V_LU); end
        tick();
        EX_Mem_Read_EN = 0; EX_Reg_File_EN = 0; EX_rd = 0;
        @(negedge clk);
        n_vec++;
        if (outv !== V_IDLE) begin n_err++; $display("FAIL load_use_after: got %b want %b", outv, V_IDLE); end
        tick();
        EX_Mem_Read_EN = 1; EX_Reg_File_EN = 1; EX_rd = 0; ID_RS1 = 0;
        @(negedge clk);
        n_vec++;
        if (outv !== V_IDLE) begin n_err++; $display("FAIL load_use_x0: got %b want %b", outv, V_IDLE); end
        tick();
        idle();
    endtask

    task automatic test_branch_load_use();
        EX_Mem_Read_EN = 1; EX_Reg_File_EN = 1; EX_rd = 9; ID_RS2 = 9; ID_RS2_used = 1; EX_Branch_Taken = 1;
        @(negedge clk);
        n_vec++;
        if (outv !== V_BR) begin n_err++; $display("FAIL branch_lu: got %b want %b", outv, V_BR); end
        tick();
        idle();
    endtask

    task automatic test_muldiv();
        EX_MulDiv_EN = 1;
        @(negedge clk);
        n_vec++;
        if (outv !== V_MDS) begin n_err++; $display("FAIL md_start: got %b want %b", outv, V_MDS); end
        tick();
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            n_vec++;
            if (outv !== V_MDW) begin n_err++; $display("FAIL md_wait[%0d]: got %b want %b", i, outv, V_MDW); end
            tick();
        end
        muldiv_done = 1;
        @(negedge clk);
        n_vec++;
        if (outv !== V_IDLE) begin n_err++; $display("FAIL md_done: got %b want %b", outv, V_IDLE); end
        tick();
        EX_MulDiv_EN = 0;
        @(negedge clk);
        n_vec++;
        if (outv !== V_IDLE) begin n_err++; $display("FAIL md_run: got %b want %b", outv, V_IDLE); end
        tick();
        idle();
    endtask

    task automatic test_counters();
        int es, ef;
`ifdef HAZARD_PERF_COUNTERS_EN
        es = 35; ef = 2;
`else
        es = 0; ef = 0;
`endif
        @(negedge clk);
        n_vec++;
        if (stall_cycles !== 32'(es)) begin n_err++; $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, es); end
        n_vec++;
        if (flush_cycles !== 32'(ef)) begin n_err++; $display("FAIL flush_cycles: got %0d want %0d", flush_cycles, ef); end
    endtask

    task automatic test_dmem_wait();
        MEM_Mem_Access = 1; dmem_ready = 0; EX_Branch_Taken = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (outv !== V_MEM) begin n_err++; $display("FAIL dmem_wait[%0d]: got %b want %b", i, outv, V_MEM); end
            tick();
        end
        dmem_ready = 1;
        @(negedge clk);
        n_vec++;
        if (outv !== V_BR) begin n_err++; $display("FAIL dmem_ready_br: got %b want %b", outv, V_BR); end
        tick();
        idle();
    endtask

    task automatic test_timeout();
        EX_MulDiv_EN = 1;
        tick();
        for (int i = 1; i <= T; i++) begin
            @(negedge clk);
            n_vec++;
            if (outv !== (i == T ? V_TMO : V_MDW)) begin
                n_err++; $display("FAIL timeout[%0d]: got %b want %b", i, outv, i == T ? V_TMO : V_MDW);
            end
            tick();
        end
        EX_MulDiv_EN = 0;
        @(negedge clk);
        n_vec++;
        if (outv !== V_IDLE) begin n_err++; $display("FAIL timeout_run: got %b want %b", outv, V_IDLE); end
        tick();
    endtask

    task automatic test_reset_wait();
        int pulses = 0, stalls = 0;
        EX_MulDiv_EN = 1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        reset = 1;
        @(negedge clk);
        n_vec++;
        if (outv !== V_IDLE) begin n_err++; $display("FAIL reset_wait: got %b want %b", outv, V_IDLE); end
        tick();
        reset = 0; EX_MulDiv_EN = 0;
        for (int i = 0; i < T + 5; i++) begin
            @(negedge clk);
            pulses += int'(muldiv_timeout);
            stalls += int'(stall_pc);
            tick();
        end
        n_vec++;
        if (pulses != 0 || stalls != 0) begin
            n_err++; $display("FAIL reset_wait_run: got %0d pulses %0d stalls want 0/0", pulses, stalls);
        end
    endtask

    task automatic test_random();
        logic [9:0] e;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(63) == 0);
            ID_RS1 = 5'($urandom_range(3)); ID_RS2 = 5'($urandom_range(3)); EX_rd = 5'($urandom_range(3));
            ID_RS1_used = 1'($urandom); ID_RS2_used = 1'($urandom);
            EX_Reg_File_EN = 1'($urandom); EX_Mem_Read_EN = 1'($urandom);
            EX_MulDiv_EN = ($urandom_range(7) == 0); EX_Branch_Taken = ($urandom_range(7) == 0);
            MEM_Mem_Access = ($urandom_range(3) == 0); dmem_ready = 1'($urandom);
            muldiv_done = ($urandom_range(15) == 0);
            @(negedge clk);
            e = exp_vec();
            n_vec++;
            if (outv !== e) begin n_err++; $display("FAIL random[%0d]: got %b want %b", i, outv, e); end
`ifdef HAZARD_PERF_COUNTERS_EN
            n_vec++;
            if (stall_cycles !== 32'(m_sc) || flush_cycles !== 32'(m_fc)) begin
                n_err++; $display("FAIL random_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cycles, flush_cycles, m_sc, m_fc);
            end
`endif
            tick();
        end
        idle(); reset = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_muldiv();
        test_counters();
        test_dmem_wait();
        test_timeout();
        test_reset_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
